// File: rtl/dma_mem_reader.sv
// Memory-to-device DMA read channel: fetches count words from saddr over the
// read_mem/grant/ready bus and hands each one to the device on a valid/ack handshake.
module dma_mem_reader #(
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  reg_sel,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        read_mem,
  output logic [31:0] adbus,
  input  logic [31:0] bus_rdata,
  input  logic        grant,
  input  logic        ready,
  output logic [31:0] dev_data,
  output logic        dev_valid,
  input  logic        dev_ack,
  input  logic        dev_error,
  output logic        irq,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_XFER    = 3'd2;
  localparam logic [2:0] S_DELIVER = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_SADDR  = 2'd1;
  localparam logic [1:0] SEL_COUNT  = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  // Handshakes: the bus word is taken on the first clk edge where the block is in
  // XFER and ready=1; the device word is taken on the first edge where
  // dev_valid=1 and dev_ack=1. dev_data does not change while dev_valid=1.

  logic [2:0]       state_q, state_d;
  logic [31:0]      saddr_q, saddr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ie_q, ie_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             irq_q, irq_d;
  logic [31:0]      dev_data_q, dev_data_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        busy;
  logic        wr_ctrl, wr_saddr, wr_count, wr_status;
  logic        go;
  logic [31:0] count_rd;

  always_comb begin
    busy      = (state_q == S_REQ) || (state_q == S_XFER) || (state_q == S_DELIVER);
    wr_ctrl   = reg_wr && (reg_sel == SEL_CTRL);
    wr_saddr  = reg_wr && (reg_sel == SEL_SADDR);
    wr_count  = reg_wr && (reg_sel == SEL_COUNT);
    wr_status = reg_wr && (reg_sel == SEL_STATUS);
    go        = wr_ctrl && reg_wdata[0];
    count_rd  = 32'(count_q);
  end

  always_comb begin
    state_d    = state_q;
    saddr_d    = saddr_q;
    count_d    = count_q;
    ie_d       = ie_q;
    done_d     = done_q;
    err_d      = err_q;
    dev_data_d = dev_data_q;
    rdata_d    = rdata_q;

    if (wr_ctrl)
      ie_d = reg_wdata[1];
    if (wr_saddr && !busy)
      saddr_d = reg_wdata;
    if (wr_count && !busy)
      count_d = reg_wdata[CNT_W-1:0];
    if (wr_status && reg_wdata[0]) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    // Setting done comes after the W1C above so a coincident set wins.
    case (state_q)
      S_IDLE: begin
        if (go) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (count_q != '0) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dev_error) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (grant) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (dev_error) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (ready) begin
          dev_data_d = bus_rdata;
          saddr_d    = saddr_q + 32'(ADDR_STEP);
          count_d    = count_q - CNT_W'(1);
          state_d    = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (dev_error) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (dev_ack) begin
          if (count_q != '0) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    irq_d = done_d & ie_d;

    if (reg_rd) begin
      case (reg_sel)
        SEL_CTRL:   rdata_d = {30'd0, ie_q, 1'b0};
        SEL_SADDR:  rdata_d = saddr_q;
        SEL_COUNT:  rdata_d = count_rd;
        SEL_STATUS: rdata_d = {29'd0, err_q, busy, done_q};
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      saddr_q    <= 32'd0;
      count_q    <= '0;
      ie_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      dev_data_q <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      saddr_q    <= saddr_d;
      count_q    <= count_d;
      ie_q       <= ie_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      dev_data_q <= dev_data_d;
      rdata_q    <= rdata_d;
    end
  end

  // Bus and device outputs decode straight from the registered state.
  always_comb begin
    read_mem  = (state_q == S_REQ) || (state_q == S_XFER);
    adbus     = (state_q == S_XFER) ? saddr_q : 32'd0;
    dev_valid = (state_q == S_DELIVER);
    dev_data  = dev_data_q;
    irq       = irq_q;
    reg_rdata = rdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_dma_mem_reader.sv
// Directed bench for dma_mem_reader: bus/device responders with programmable delays
// plus queues of hand-computed expected addresses and words.
module tb_dma_mem_reader;

  logic        clk;
  logic        rst;
  logic [1:0]  reg_sel;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        read_mem;
  logic [31:0] adbus;
  logic [31:0] bus_rdata;
  logic        grant;
  logic        ready;
  logic [31:0] dev_data;
  logic        dev_valid;
  logic        dev_ack;
  logic        dev_error;
  logic        irq;
  logic [2:0]  dbg_state;

  dma_mem_reader #(.ADDR_STEP(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .read_mem(read_mem), .adbus(adbus),
    .bus_rdata(bus_rdata), .grant(grant), .ready(ready), .dev_data(dev_data),
    .dev_valid(dev_valid), .dev_ack(dev_ack), .dev_error(dev_error), .irq(irq),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_n = 0;
  int fail_n   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  int grant_dly = 0;
  int ready_dly = 1;
  int ack_dly   = 0;
  int req_cnt, gnt_cnt, ack_cnt;
  int extra_cnt   = 0;
  int stable_viol = 0;
  int valid_cnt   = 0;
  logic rm_seen   = 1'b0;
  logic prev_valid = 1'b0;
  logic [31:0] held_data = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hA0 + {26'd0, addr[7:2]};
  endfunction

  // bus responder and address scoreboard
  always @(negedge clk) begin
    if (read_mem) rm_seen = 1'b1;
    if (rst || !read_mem) begin
      grant = 1'b0; ready = 1'b0; req_cnt = 0; gnt_cnt = 0;
    end else if (ready) begin
      ready = 1'b0;
    end else if (!grant) begin
      if (req_cnt >= grant_dly) begin
        grant = 1'b1;
        check("req_wait", 32'(req_cnt), 32'(grant_dly));
      end else req_cnt++;
    end else if (gnt_cnt >= ready_dly) begin
      ready = 1'b1;
      bus_rdata = mem_word(adbus);
      if (exp_addr_q.size() > 0) check("adbus", adbus, exp_addr_q.pop_front());
      else extra_cnt++;
    end else gnt_cnt++;
  end

  // device responder and word scoreboard
  always @(negedge clk) begin
    if (dev_valid) begin
      if (!prev_valid) begin
        held_data = dev_data;
        valid_cnt++;
      end else if (dev_data !== held_data) stable_viol++;
    end
    prev_valid = dev_valid;
    if (rst || !dev_valid) begin
      dev_ack = 1'b0; ack_cnt = 0;
    end else if (!dev_ack) begin
      if (ack_cnt >= ack_dly) begin
        dev_ack = 1'b1;
        if (exp_q.size() > 0) check("dev_data", dev_data, exp_q.pop_front());
        else extra_cnt++;
      end else ack_cnt++;
    end
  end

  // driver tasks (called at negedge)
  task automatic reg_write(input logic [1:0] sel, input logic [31:0] d);
    reg_sel = sel; reg_wdata = d; reg_wr = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] sel, output logic [31:0] d);
    reg_sel = sel; reg_rd = 1'b1;
    @(negedge clk);
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic wait_done(input int budget);
    logic [31:0] st;
    st = 32'd0;
    for (int i = 0; i < budget; i++) begin
      reg_read(2'd3, st);
      if (st[0]) break;
    end
    check("done_poll", {31'd0, st[0]}, 32'd1);
  endtask

  task automatic end_of_test(input string tag);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({tag, "_extra"}, 32'(extra_cnt), 32'd0);
    check({tag, "_stable"}, 32'(stable_viol), 32'd0);
    exp_q.delete(); exp_addr_q.delete();
    extra_cnt = 0; stable_viol = 0;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; reg_sel = 2'd0; reg_wr = 1'b0; reg_rd = 1'b0; reg_wdata = 32'd0;
    dev_error = 1'b0; bus_rdata = 32'd0; grant = 1'b0; ready = 1'b0; dev_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_read_mem", {31'd0, read_mem}, 32'd0);
    check("rst_adbus", adbus, 32'd0);
    check("rst_dev_valid", {31'd0, dev_valid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    reg_read(2'd3, r); check("rst_status", r, 32'd0);

    // 3-word transfer at 0x100 with interrupt
    grant_dly = 0; ready_dly = 1; ack_dly = 0;
    exp_addr_q = '{32'h100, 32'h104, 32'h108};
    exp_q = '{32'hA0, 32'hA1, 32'hA2};
    reg_write(2'd1, 32'h100);
    reg_write(2'd2, 32'd3);
    reg_write(2'd0, 32'd3);
    wait_done(200);
    reg_read(2'd2, r); check("t1_count", r, 32'd0);
    reg_read(2'd1, r); check("t1_saddr", r, 32'h10C);
    reg_read(2'd3, r); check("t1_status", r, 32'd1);
    check("t1_irq", {31'd0, irq}, 32'd1);
    end_of_test("t1");
    reg_write(2'd3, 32'd1);
    check("t1_irq_w1c", {31'd0, irq}, 32'd0);
    reg_read(2'd3, r); check("t1_status_w1c", r, 32'd0);

    // zero count: done straight away, no bus activity
    rm_seen = 1'b0;
    reg_write(2'd2, 32'd0);
    reg_write(2'd0, 32'd3);
    reg_read(2'd3, r); check("t2_status", r, 32'd1);
    check("t2_irq", {31'd0, irq}, 32'd1);
    reg_write(2'd0, 32'd1);
    reg_read(2'd3, r); check("t2_status_noie", r, 32'd1);
    check("t2_irq_noie", {31'd0, irq}, 32'd0);
    check("t2_no_read_mem", {31'd0, rm_seen}, 32'd0);

    // address wrap
    exp_addr_q = '{32'hFFFF_FFFC, 32'h0000_0000};
    exp_q = '{32'hDF, 32'hA0};
    reg_write(2'd1, 32'hFFFF_FFFC);
    reg_write(2'd2, 32'd2);
    reg_write(2'd0, 32'd1);
    wait_done(200);
    reg_read(2'd1, r); check("t3_saddr", r, 32'h4);
    reg_read(2'd2, r); check("t3_count", r, 32'd0);
    check("t3_irq", {31'd0, irq}, 32'd0);
    end_of_test("t3");

    // slow grant and slow device
    grant_dly = 7; ready_dly = 1; ack_dly = 5;
    exp_addr_q = '{32'h200, 32'h204};
    exp_q = '{32'hA0, 32'hA1};
    reg_write(2'd1, 32'h200);
    reg_write(2'd2, 32'd2);
    reg_write(2'd0, 32'd3);
    wait_done(300);
    reg_read(2'd3, r); check("t4_status", r, 32'd1);
    end_of_test("t4");

    // device error during the second word of four
    grant_dly = 0; ready_dly = 1; ack_dly = 3;
    exp_addr_q = '{32'h300, 32'h304};
    exp_q = '{32'hA0};
    valid_cnt = 0;
    reg_write(2'd1, 32'h300);
    reg_write(2'd2, 32'd4);
    reg_write(2'd0, 32'd3);
    for (int i = 0; i < 200; i++) begin
      if (valid_cnt >= 2) break;
      @(negedge clk); #1;
    end
    check("t5_second_valid", 32'(valid_cnt), 32'd2);
    dev_error = 1'b1;
    @(negedge clk);
    dev_error = 1'b0;
    #1;
    check("t5_read_mem", {31'd0, read_mem}, 32'd0);
    check("t5_dev_valid", {31'd0, dev_valid}, 32'd0);
    reg_read(2'd3, r); check("t5_status", r, 32'd5);
    reg_read(2'd2, r); check("t5_count", r, 32'd2);
    reg_read(2'd1, r); check("t5_saddr", r, 32'h308);
    check("t5_irq", {31'd0, irq}, 32'd1);
    end_of_test("t5");

    // writes while busy are ignored
    grant_dly = 1; ready_dly = 1; ack_dly = 4;
    exp_addr_q = '{32'h400, 32'h404, 32'h408};
    exp_q = '{32'hA0, 32'hA1, 32'hA2};
    reg_write(2'd1, 32'h400);
    reg_write(2'd2, 32'd3);
    reg_write(2'd0, 32'd3);
    reg_write(2'd2, 32'd9);
    reg_write(2'd1, 32'h800);
    reg_write(2'd0, 32'd3);
    wait_done(300);
    reg_read(2'd2, r); check("t6_count", r, 32'd0);
    reg_read(2'd1, r); check("t6_saddr", r, 32'h40C);
    rm_seen = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_second", {31'd0, rm_seen}, 32'd0);
    end_of_test("t6");

    // reset mid-XFER
    grant_dly = 0; ready_dly = 4; ack_dly = 0;
    reg_write(2'd1, 32'h500);
    reg_write(2'd2, 32'd2);
    reg_write(2'd0, 32'd3);
    for (int i = 0; i < 100; i++) begin
      if (dbg_state == 3'd2) break;
      @(negedge clk); #1;
    end
    check("t7_in_xfer", {31'd0, read_mem & grant}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t7_read_mem", {31'd0, read_mem}, 32'd0);
    check("t7_adbus", adbus, 32'd0);
    check("t7_dev_valid", {31'd0, dev_valid}, 32'd0);
    check("t7_dev_data", dev_data, 32'd0);
    check("t7_irq", {31'd0, irq}, 32'd0);
    check("t7_rdata", reg_rdata, 32'd0);
    reg_read(2'd3, r); check("t7_status", r, 32'd0);
    reg_read(2'd2, r); check("t7_count", r, 32'd0);
    exp_q.delete(); exp_addr_q.delete();
    check("t7_extra", 32'(extra_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
